// File: rtl/demux2_pkg.sv
// ============================================================================
// Module   : demux2_pkg
// Purpose  : Shared types and constants for the demux2 register-slice demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux2_pkg;

  // Occupancy of the two-entry slice. 2'b11 is unreachable and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } demux2_state_t;

  // Width of the optional per-port transfer counters.
  localparam int PERF_CNT_W = 32;

  // True when the slice holds at least one item.
  function automatic logic state_has_item(input demux2_state_t s);
    return (s == FULL) || (s == SKID);
  endfunction

endpackage : demux2_pkg

`default_nettype wire

// File: rtl/skid_slice.sv
// ============================================================================
// Module   : skid_slice
// Purpose  : Two-entry valid/ready register slice (main + skid entry).
//            Breaks every combinational path between producer and consumer:
//            in_ready and out_valid/out_data all come straight from flops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_slice
  import demux2_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  demux2_state_t    state_q;
  logic [WIDTH-1:0] m_q;         // main entry, presented downstream
  logic [WIDTH-1:0] s_q;         // skid entry, absorbs the item in flight when a stall begins
  logic             in_ready_q;
  logic             out_valid_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Slice state machine: occupancy, both entries and the registered handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            m_q         <= in_data;
            out_valid_q <= 1'b1;
            state_q     <= FULL;
          end
        end
        FULL: begin
          if (out_fire && in_fire) begin
            m_q <= in_data;
          end else if (out_fire) begin
            m_q         <= '0;
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end else if (in_fire) begin
            // Stall just began: park the extra item and stop accepting.
            s_q        <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= SKID;
          end
        end
        SKID: begin
          if (out_fire) begin
            m_q        <= s_q;
            s_q        <= '0;
            in_ready_q <= 1'b1;
            state_q    <= FULL;
          end
        end
        default: begin
          state_q     <= EMPTY;
          m_q         <= '0;
          s_q         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = m_q;
  assign busy      = state_has_item(state_q);

endmodule : skid_slice

`default_nettype wire

// File: rtl/demux2.sv
// ============================================================================
// Module   : demux2
// Purpose  : Two-way registered demultiplexer with valid/ready handshake.
//            Each item carries a destination bit and is steered to port 0
//            (data RAM) or port 1 (MMIO). Strict FIFO order across ports.
// Config   : DEMUX2_PERF_EN - adds 32-bit per-port transfer counters cnt0/cnt1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux2
  import demux2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             busy
`ifdef DEMUX2_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] cnt0,
  output logic [PERF_CNT_W-1:0] cnt1
`endif
);

  logic             head_valid;
  logic             head_ready;
  logic [WIDTH:0]   head_item;   // {sel, data}
  logic             head_sel;
  logic [WIDTH-1:0] head_data;

  skid_slice #(
    .WIDTH (WIDTH + 1)
  ) u_slice (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_sel, in_data}),
    .out_valid (head_valid),
    .out_ready (head_ready),
    .out_data  (head_item),
    .busy      (busy)
  );

  assign head_sel  = head_item[WIDTH];
  assign head_data = head_item[WIDTH-1:0];

  // Only the head item's port can release it, which gives head-of-line blocking.
  assign head_ready = head_sel ? out1_ready : out0_ready;

  // Port decode from registered state only; the idle port shows zero data.
  assign out0_valid = head_valid & ~head_sel;
  assign out1_valid = head_valid &  head_sel;
  assign out0_data  = out0_valid ? head_data : '0;
  assign out1_data  = out1_valid ? head_data : '0;

`ifdef DEMUX2_PERF_EN
  logic [PERF_CNT_W-1:0] cnt0_q, cnt0_d;
  logic [PERF_CNT_W-1:0] cnt1_q, cnt1_d;

  // Next count: one increment per accepted transfer, wrapping naturally.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (out0_valid && out0_ready) cnt0_d = cnt0_q + 1'b1;
    if (out1_valid && out1_ready) cnt1_d = cnt1_q + 1'b1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule : demux2

`default_nettype wire

// File: tb/tb_demux2.sv
// ============================================================================
// Module   : tb_demux2
// Purpose  : Directed, table-driven self-checking bench for demux2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux2;

  localparam int WIDTH = 8;

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             busy;
`ifdef DEMUX2_PERF_EN
  logic [31:0]      cnt0;
  logic [31:0]      cnt1;
`endif

  int n_cmp;
  int n_err;

  demux2 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .busy       (busy)
`ifdef DEMUX2_PERF_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       sel;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic       e_busy;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic v0, input logic [7:0] d0,
                          input logic v1, input logic [7:0] d1, input logic bz);
    chk({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, rdy});
    chk({tag, ".out0_valid"}, {31'd0, out0_valid}, {31'd0, v0});
    chk({tag, ".out0_data"},  {24'd0, out0_data},  {24'd0, d0});
    chk({tag, ".out1_valid"}, {31'd0, out1_valid}, {31'd0, v1});
    chk({tag, ".out1_data"},  {24'd0, out1_data},  {24'd0, d1});
    chk({tag, ".busy"},       {31'd0, busy},       {31'd0, bz});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    //            iv sel  d      r0 r1  rdy v0 d0     v1 d1     busy
    // single item to port 1
    vecs[0]  = '{1, 1, 8'hA5, 0, 1,  1, 0, 8'h00, 1, 8'hA5, 1};
    vecs[1]  = '{0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 8'h00, 0};
    // streaming, both ports ready
    vecs[2]  = '{1, 0, 8'h01, 1, 1,  1, 1, 8'h01, 0, 8'h00, 1};
    vecs[3]  = '{1, 1, 8'h02, 1, 1,  1, 0, 8'h00, 1, 8'h02, 1};
    vecs[4]  = '{1, 0, 8'h03, 1, 1,  1, 1, 8'h03, 0, 8'h00, 1};
    vecs[5]  = '{0, 0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 8'h00, 0};
    // backpressure on port 0
    vecs[6]  = '{1, 0, 8'h10, 0, 1,  1, 1, 8'h10, 0, 8'h00, 1};
    vecs[7]  = '{1, 0, 8'h11, 0, 1,  0, 1, 8'h10, 0, 8'h00, 1};
    vecs[8]  = '{1, 0, 8'h12, 0, 1,  0, 1, 8'h10, 0, 8'h00, 1};
    vecs[9]  = '{1, 0, 8'h12, 1, 1,  1, 1, 8'h11, 0, 8'h00, 1};
    vecs[10] = '{1, 0, 8'h12, 1, 1,  1, 1, 8'h12, 0, 8'h00, 1};
    vecs[11] = '{0, 0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 8'h00, 0};
    // head-of-line blocking
    vecs[12] = '{1, 0, 8'h20, 0, 1,  1, 1, 8'h20, 0, 8'h00, 1};
    vecs[13] = '{1, 1, 8'h21, 0, 1,  0, 1, 8'h20, 0, 8'h00, 1};
    vecs[14] = '{0, 0, 8'h00, 0, 1,  0, 1, 8'h20, 0, 8'h00, 1};
    vecs[15] = '{0, 0, 8'h00, 1, 1,  1, 0, 8'h00, 1, 8'h21, 1};
    vecs[16] = '{0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 8'h00, 0};

    // Reset held with a valid item offered: nothing may be captured.
    resetn     = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    in_data    = 8'hFF;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step();
    step();
    chk_outs("reset_hold", 1, 0, 8'h00, 0, 8'h00, 0);
`ifdef DEMUX2_PERF_EN
    chk("reset_hold.cnt0", cnt0, 32'd0);
    chk("reset_hold.cnt1", cnt1, 32'd0);
`endif
    resetn   = 1'b1;
    in_valid = 1'b0;
    step();
    chk_outs("reset_release", 1, 0, 8'h00, 0, 8'h00, 0);

    // Table: inputs applied for one cycle, outputs checked after the edge.
    for (int i = 0; i < 17; i++) begin
      in_valid   = vecs[i].iv;
      in_sel     = vecs[i].sel;
      in_data    = vecs[i].d;
      out0_ready = vecs[i].r0;
      out1_ready = vecs[i].r1;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_v0, vecs[i].e_d0,
               vecs[i].e_v1, vecs[i].e_d1, vecs[i].e_busy);
    end

    // Drive into SKID, then assert reset mid-cycle: outputs clear at once.
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 8'h30;
    step();
    in_data    = 8'h31;
    step();
    chk_outs("skid_entry", 0, 1, 8'h30, 0, 8'h00, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk_outs("async_reset", 1, 0, 8'h00, 0, 8'h00, 0);
    step();
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    step();
    resetn = 1'b1;
    step();
    chk_outs("post_reset_idle", 1, 0, 8'h00, 0, 8'h00, 0);

    // Three port-0 and two port-1 transfers, both ports ready.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sel   = (i == 1 || i == 3);
      in_data  = 8'h40 + 8'(i);
      step();
      if (i == 1) chk_outs("count_seq1", 1, 0, 8'h00, 1, 8'h41, 1);
      if (i == 2) chk_outs("count_seq2", 1, 1, 8'h42, 0, 8'h00, 1);
    end
    in_valid = 1'b0;
    step();
    chk_outs("count_done", 1, 0, 8'h00, 0, 8'h00, 0);
`ifdef DEMUX2_PERF_EN
    chk("cnt0", cnt0, 32'd3);
    chk("cnt1", cnt1, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux2

`default_nettype wire
